// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory stage: funct3 encodings, FSM states
// and access-size helpers.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic {IDLE, LOAD} state_t;

  function automatic logic [3:0] size_bytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 4'd1;
      2'b01:   return 4'd2;
      2'b10:   return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic is_aligned(input logic [2:0] f3, input logic [2:0] off);
    logic [3:0] m;
    m = size_bytes(f3) - 4'd1;
    return (off & m[2:0]) == 3'b000;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Private data RAM: 64-bit doublewords, byte-enabled synchronous write and
// registered synchronous read (read-during-write returns old data).
module dmem_ram #(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [7:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [63:0]   wdata,
  output logic [63:0]   rdata
);

  logic [63:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_stage.sv
// Memory-access / writeback stage: loads, stores and pass-through of ALU
// results to the register-file write port, with alignment/legality checks.
module data_mem_stage
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_mem_read,
  input  logic        in_mem_write,
  input  logic [2:0]  in_funct3,
  input  logic [63:0] in_alu_result,
  input  logic [63:0] in_store_data,
  input  logic [4:0]  in_rd,
  input  logic        in_reg_write,
  output logic        out_valid,
  output logic [4:0]  out_rd,
  output logic [63:0] out_wdata,
  output logic        out_reg_write,
  output logic        out_fault
);

  localparam int unsigned AW = $clog2(DEPTH);

  state_t state_q, state_d;

  logic          accept, is_mem, misaligned, illegal, conflict, fault;
  logic [2:0]    off;
  logic [AW-1:0] idx;
  logic          ram_we, ram_re;
  logic [7:0]    lane_mask, ram_be;
  logic [63:0]   ram_wdata, ram_rdata;

  logic [2:0]    ld_f3_q, ld_off_q;
  logic [4:0]    ld_rd_q;
  logic          ld_rw_q;
  logic [63:0]   lane, ld_value;
  logic          sext;

  assign in_ready = (state_q == IDLE) && !rst;
  assign accept   = in_valid && in_ready;

  assign off = in_alu_result[2:0];
  assign idx = in_alu_result[AW+2:3];

  assign is_mem     = in_mem_read || in_mem_write;
  assign misaligned = !is_aligned(in_funct3, off);
  assign illegal    = (in_funct3 == 3'b111) || (in_mem_write && in_funct3[2]);
  assign conflict   = in_mem_read && in_mem_write;
  assign fault      = is_mem && (misaligned || illegal || conflict);

  assign ram_we = accept && in_mem_write && !fault;
  assign ram_re = accept && in_mem_read && !fault;

  always_comb begin
    case (in_funct3[1:0])
      2'b00:   lane_mask = 8'h01;
      2'b01:   lane_mask = 8'h03;
      2'b10:   lane_mask = 8'h0F;
      default: lane_mask = 8'hFF;
    endcase
  end

  assign ram_be    = lane_mask << off;
  assign ram_wdata = in_store_data << {off, 3'b000};

  dmem_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .be    (ram_be),
    .addr  (idx),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ram_re) state_d = LOAD;
      LOAD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Lane select and extension on the registered RAM word from the accept edge.
  always_comb begin
    lane = ram_rdata >> {ld_off_q, 3'b000};
    sext = !ld_f3_q[2];
    case (ld_f3_q[1:0])
      2'b00:   ld_value = {{56{sext & lane[7]}},  lane[7:0]};
      2'b01:   ld_value = {{48{sext & lane[15]}}, lane[15:0]};
      2'b10:   ld_value = {{32{sext & lane[31]}}, lane[31:0]};
      default: ld_value = lane;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_reg_write <= 1'b0;
      out_fault     <= 1'b0;
      out_rd        <= '0;
      out_wdata     <= '0;
      ld_f3_q       <= '0;
      ld_off_q      <= '0;
      ld_rd_q       <= '0;
      ld_rw_q       <= 1'b0;
    end else begin
      out_valid     <= 1'b0;
      out_reg_write <= 1'b0;
      out_fault     <= 1'b0;
      if (state_q == LOAD) begin
        out_valid     <= 1'b1;
        out_rd        <= ld_rd_q;
        out_wdata     <= ld_value;
        out_reg_write <= ld_rw_q;
      end else if (ram_re) begin
        ld_f3_q  <= in_funct3;
        ld_off_q <= off;
        ld_rd_q  <= in_rd;
        ld_rw_q  <= in_reg_write;
      end else if (accept) begin
        out_valid     <= 1'b1;
        out_rd        <= in_rd;
        out_fault     <= fault;
        out_reg_write <= !is_mem && in_reg_write;
        if (!is_mem) out_wdata <= in_alu_result;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_stage.sv
// Directed bench for data_mem_stage: vector table plus hand-written sequences
// for back-to-back traffic and reset during a pending load.
module tb_data_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_mem_read;
  logic        in_mem_write;
  logic [2:0]  in_funct3;
  logic [63:0] in_alu_result;
  logic [63:0] in_store_data;
  logic [4:0]  in_rd;
  logic        in_reg_write;
  logic        out_valid;
  logic [4:0]  out_rd;
  logic [63:0] out_wdata;
  logic        out_reg_write;
  logic        out_fault;

  int n_cmp  = 0;
  int n_fail = 0;

  data_mem_stage #(.DEPTH(512)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_mem_read   (in_mem_read),
    .in_mem_write  (in_mem_write),
    .in_funct3     (in_funct3),
    .in_alu_result (in_alu_result),
    .in_store_data (in_store_data),
    .in_rd         (in_rd),
    .in_reg_write  (in_reg_write),
    .out_valid     (out_valid),
    .out_rd        (out_rd),
    .out_wdata     (out_wdata),
    .out_reg_write (out_reg_write),
    .out_fault     (out_fault)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        mr;
    logic        mw;
    logic [2:0]  f3;
    logic [63:0] alu;
    logic [63:0] sd;
    logic [4:0]  rd;
    logic        rw;
    logic        e_fault;
    logic        e_rw;
    logic        chk_wd;
    logic [63:0] e_wd;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic mr, input logic mw, input logic [2:0] f3,
                              input logic [63:0] alu, input logic [63:0] sd,
                              input logic [4:0] rd, input logic rw, input logic e_fault,
                              input logic e_rw, input logic chk_wd, input logic [63:0] e_wd,
                              input int lat);
    vec_t v;
    v.mr = mr; v.mw = mw; v.f3 = f3; v.alu = alu; v.sd = sd; v.rd = rd; v.rw = rw;
    v.e_fault = e_fault; v.e_rw = e_rw; v.chk_wd = chk_wd; v.e_wd = e_wd; v.lat = lat;
    return v;
  endfunction

  task automatic drive(input logic mr, input logic mw, input logic [2:0] f3,
                       input logic [63:0] alu, input logic [63:0] sd,
                       input logic [4:0] rd, input logic rw);
    in_mem_read   = mr;
    in_mem_write  = mw;
    in_funct3     = f3;
    in_alu_result = alu;
    in_store_data = sd;
    in_rd         = rd;
    in_reg_write  = rw;
    in_valid      = 1'b1;
  endtask

  // Called at a negedge; returns at a negedge.
  task automatic run_vec(input vec_t v, input string name);
    int waited;
    int lat;
    bit got;
    waited = 0;
    while (!in_ready && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    drive(v.mr, v.mw, v.f3, v.alu, v.sd, v.rd, v.rw);
    @(posedge clk);
    #1 in_valid = 1'b0;
    got = 0;
    lat = 0;
    for (int i = 1; i <= 4 && !got; i++) begin
      @(negedge clk);
      if (i == 1) check({name, " in_ready"}, 64'(in_ready), (v.lat == 2) ? 64'd0 : 64'd1);
      if (out_valid) begin
        got = 1;
        lat = i;
      end
    end
    check({name, " latency"}, 64'(lat), 64'(v.lat));
    if (got) begin
      check({name, " fault"}, 64'(out_fault), 64'(v.e_fault));
      check({name, " reg_write"}, 64'(out_reg_write), 64'(v.e_rw));
      check({name, " rd"}, 64'(out_rd), 64'(v.rd));
      if (v.chk_wd) check({name, " wdata"}, out_wdata, v.e_wd);
      @(negedge clk);
      check({name, " valid_drop"}, 64'(out_valid), 64'd0);
    end
  endtask

  localparam int NV = 22;
  vec_t vecs [NV];

  initial begin
    //                mr    mw    f3      alu               store                  rd     rw    flt   erw   chk   exp_wdata              lat
    vecs[0]  = mk(1'b0, 1'b0, 3'b000, 64'h1234, 64'h0,                 5'd5,  1'b1, 1'b0, 1'b1, 1'b1, 64'h1234,              1);
    vecs[1]  = mk(1'b0, 1'b0, 3'b111, 64'h55,   64'h0,                 5'd9,  1'b0, 1'b0, 1'b0, 1'b1, 64'h55,                1);
    vecs[2]  = mk(1'b0, 1'b1, 3'b011, 64'h40,   64'h8877665544332211,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 64'h0,                 1);
    vecs[3]  = mk(1'b1, 1'b0, 3'b011, 64'h40,   64'h0,                 5'd6,  1'b1, 1'b0, 1'b1, 1'b1, 64'h8877665544332211,  2);
    vecs[4]  = mk(1'b1, 1'b0, 3'b000, 64'h47,   64'h0,                 5'd7,  1'b1, 1'b0, 1'b1, 1'b1, 64'hFFFFFFFFFFFFFF88,  2);
    vecs[5]  = mk(1'b1, 1'b0, 3'b100, 64'h47,   64'h0,                 5'd8,  1'b1, 1'b0, 1'b1, 1'b1, 64'h0000000000000088,  2);
    vecs[6]  = mk(1'b1, 1'b0, 3'b001, 64'h46,   64'h0,                 5'd10, 1'b1, 1'b0, 1'b1, 1'b1, 64'hFFFFFFFFFFFF8877,  2);
    vecs[7]  = mk(1'b1, 1'b0, 3'b110, 64'h44,   64'h0,                 5'd11, 1'b1, 1'b0, 1'b1, 1'b1, 64'h0000000088776655,  2);
    vecs[8]  = mk(1'b1, 1'b0, 3'b010, 64'h44,   64'h0,                 5'd12, 1'b0, 1'b0, 1'b0, 1'b1, 64'hFFFFFFFF88776655,  2);
    vecs[9]  = mk(1'b1, 1'b0, 3'b101, 64'h40,   64'h0,                 5'd13, 1'b1, 1'b0, 1'b1, 1'b1, 64'h0000000000002211,  2);
    vecs[10] = mk(1'b0, 1'b1, 3'b000, 64'h41,   64'h11223344556677AB,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 64'h0,                 1);
    vecs[11] = mk(1'b1, 1'b0, 3'b011, 64'h40,   64'h0,                 5'd14, 1'b1, 1'b0, 1'b1, 1'b1, 64'h887766554433AB11,  2);
    vecs[12] = mk(1'b1, 1'b0, 3'b001, 64'h40,   64'h0,                 5'd15, 1'b1, 1'b0, 1'b1, 1'b1, 64'hFFFFFFFFFFFFAB11,  2);
    vecs[13] = mk(1'b1, 1'b0, 3'b010, 64'h42,   64'h0,                 5'd16, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0,                 1);
    vecs[14] = mk(1'b0, 1'b1, 3'b001, 64'h41,   64'hFFFF,              5'd17, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0,                 1);
    vecs[15] = mk(1'b0, 1'b1, 3'b100, 64'h40,   64'hFF,                5'd18, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0,                 1);
    vecs[16] = mk(1'b1, 1'b1, 3'b011, 64'h40,   64'h0,                 5'd19, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0,                 1);
    vecs[17] = mk(1'b1, 1'b0, 3'b111, 64'h40,   64'h0,                 5'd20, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0,                 1);
    vecs[18] = mk(1'b1, 1'b0, 3'b011, 64'h40,   64'h0,                 5'd21, 1'b1, 1'b0, 1'b1, 1'b1, 64'h887766554433AB11,  2);
    vecs[19] = mk(1'b0, 1'b1, 3'b011, 64'h1008, 64'hDEAD,              5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 64'h0,                 1);
    vecs[20] = mk(1'b1, 1'b0, 3'b011, 64'h0008, 64'h0,                 5'd22, 1'b1, 1'b0, 1'b1, 1'b1, 64'hDEAD,              2);
    vecs[21] = mk(1'b1, 1'b0, 3'b000, 64'h100F, 64'h0,                 5'd23, 1'b1, 1'b0, 1'b1, 1'b1, 64'h0,                 2);

    rst = 1'b1;
    in_valid = 1'b0;
    drive(1'b0, 1'b0, 3'b000, 64'h0, 64'h0, 5'd0, 1'b0);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("reset in_ready_low", 64'(in_ready), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset out_rd", 64'(out_rd), 64'd0);
    check("reset out_wdata", out_wdata, 64'd0);
    check("reset out_reg_write", 64'(out_reg_write), 64'd0);
    check("reset out_fault", 64'(out_fault), 64'd0);
    check("reset in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < NV; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Back-to-back non-memory ops: one per cycle.
    drive(1'b0, 1'b0, 3'b000, 64'hA1, 64'h0, 5'd1, 1'b1);
    @(posedge clk);
    #1 drive(1'b0, 1'b0, 3'b000, 64'hB2, 64'h0, 5'd2, 1'b1);
    @(negedge clk);
    check("b2b first valid", 64'(out_valid), 64'd1);
    check("b2b first wdata", out_wdata, 64'hA1);
    check("b2b in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("b2b second valid", 64'(out_valid), 64'd1);
    check("b2b second wdata", out_wdata, 64'hB2);
    check("b2b second rd", 64'(out_rd), 64'd2);

    // Store at edge N, load of same doubleword at edge N+1.
    @(negedge clk);
    drive(1'b0, 1'b1, 3'b011, 64'h80, 64'h0123456789ABCDEF, 5'd0, 1'b0);
    @(posedge clk);
    #1 drive(1'b1, 1'b0, 3'b011, 64'h80, 64'h0, 5'd3, 1'b1);
    @(negedge clk);
    check("st_ld store ack", 64'(out_valid), 64'd1);
    check("st_ld store rw", 64'(out_reg_write), 64'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("st_ld load pending valid", 64'(out_valid), 64'd0);
    check("st_ld load pending ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    check("st_ld load valid", 64'(out_valid), 64'd1);
    check("st_ld load wdata", out_wdata, 64'h0123456789ABCDEF);

    // Reset while a load is pending: it must never retire.
    @(negedge clk);
    drive(1'b1, 1'b0, 3'b011, 64'h40, 64'h0, 5'd4, 1'b1);
    @(posedge clk);
    #1 begin
      in_valid = 1'b0;
      rst = 1'b1;
    end
    @(negedge clk);
    check("rst_load in_ready_low", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_load no valid", 64'(out_valid), 64'd0);
    check("rst_load in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    check("rst_load still no valid", 64'(out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
